// File: rtl/game_ctrl_if.sv
// Game sequencer bus: frame/score strobes, buttons and pixel flags in; state, gating and score out.
// No latency of its own; no backpressure, all strobes are single-cycle pulses.
interface game_ctrl_if #(
    parameter int SCORE_W = 16
);
    logic               frame_tick;
    logic               score_tick;
    logic               start_btn;
    logic               pause_btn;
    logic               video_on;
    logic               goose_px;
    logic               bean_px;
    logic [2:0]         state;
    logic               run_en;
    logic               clear_obj;
    logic               hit;
    logic [SCORE_W-1:0] score;
    logic [SCORE_W-1:0] score_hi;
    logic [2:0]         level;

    modport master (
        output frame_tick, score_tick, start_btn, pause_btn, video_on, goose_px, bean_px,
        input  state, run_en, clear_obj, hit, score, score_hi, level
    );

    modport slave (
        input  frame_tick, score_tick, start_btn, pause_btn, video_on, goose_px, bean_px,
        output state, run_en, clear_obj, hit, score, score_hi, level
    );
endinterface

// File: rtl/game_ctrl.sv
// Goose-run sequencer: IDLE/COUNTDOWN/RUN/OVER (+PAUSE when GAME_PAUSE_EN), score, high score, level.
// Latency: all state/run_en/hit/clear_obj/score outputs registered, 1 clk after the causing input.
// Backpressure: none; strobes are consumed in the cycle they arrive, early start presses are dropped.
module game_ctrl #(
    parameter int SCORE_W        = 16,
    parameter int COUNT_FRAMES   = 75,
    parameter int HOLDOFF_FRAMES = 25,
    parameter int LEVEL_STEP     = 64,
    parameter int MAX_LEVEL      = 7
) (
    input  logic         clk,
    input  logic         reset,
    game_ctrl_if.slave   bus
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_COUNT = 3'd1,
        S_RUN   = 3'd2,
        S_OVER  = 3'd3,
        S_PAUSE = 3'd4
    } state_t;

    localparam int CNT_MAX = (COUNT_FRAMES > HOLDOFF_FRAMES) ? COUNT_FRAMES : HOLDOFF_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int STEP_SH = $clog2(LEVEL_STEP);

    state_t             state_q;
    logic               run_en_q;
    logic               clear_obj_q;
    logic               hit_q;
    logic [SCORE_W-1:0] score_q;
    logic [SCORE_W-1:0] score_hi_q;
    logic [CNT_W-1:0]   frame_cnt;
    logic               start_q;
    logic               start_press;
    logic               collision;
    logic [SCORE_W-1:0] lvl_raw;

    assign start_press = bus.start_btn & ~start_q;
    assign collision   = bus.goose_px & bus.bean_px & bus.video_on;

`ifdef GAME_PAUSE_EN
    logic pause_q;
    logic pause_press;
    assign pause_press = bus.pause_btn & ~pause_q;
`else
    logic unused_pause;
    assign unused_pause = bus.pause_btn;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            run_en_q    <= 1'b0;
            clear_obj_q <= 1'b0;
            hit_q       <= 1'b0;
            score_q     <= '0;
            score_hi_q  <= '0;
            frame_cnt   <= '0;
            start_q     <= 1'b0;
`ifdef GAME_PAUSE_EN
            pause_q     <= 1'b0;
`endif
        end else begin
            start_q     <= bus.start_btn;
`ifdef GAME_PAUSE_EN
            pause_q     <= bus.pause_btn;
`endif
            clear_obj_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start_press) begin
                        state_q     <= S_COUNT;
                        score_q     <= '0;
                        clear_obj_q <= 1'b1;
                        frame_cnt   <= '0;
                    end
                end
                S_COUNT: begin
                    if (bus.frame_tick) begin
                        if (frame_cnt == CNT_W'(COUNT_FRAMES - 1)) begin
                            state_q   <= S_RUN;
                            run_en_q  <= 1'b1;
                            frame_cnt <= '0;
                        end else begin
                            frame_cnt <= frame_cnt + 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    // Collision outranks both a same-cycle score tick and a pause request.
                    if (collision) begin
                        state_q    <= S_OVER;
                        run_en_q   <= 1'b0;
                        hit_q      <= 1'b1;
                        frame_cnt  <= '0;
                        if (score_q > score_hi_q)
                            score_hi_q <= score_q;
`ifdef GAME_PAUSE_EN
                    end else if (pause_press) begin
                        state_q  <= S_PAUSE;
                        run_en_q <= 1'b0;
`endif
                    end else if (bus.score_tick && (score_q != {SCORE_W{1'b1}})) begin
                        score_q <= score_q + 1'b1;
                    end
                end
                S_OVER: begin
                    // Counter saturates at the holdoff so a long wait never wraps it back below.
                    if (start_press && (frame_cnt >= CNT_W'(HOLDOFF_FRAMES))) begin
                        state_q     <= S_COUNT;
                        hit_q       <= 1'b0;
                        score_q     <= '0;
                        clear_obj_q <= 1'b1;
                        frame_cnt   <= '0;
                    end else if (bus.frame_tick && (frame_cnt < CNT_W'(HOLDOFF_FRAMES))) begin
                        frame_cnt <= frame_cnt + 1'b1;
                    end
                end
`ifdef GAME_PAUSE_EN
                S_PAUSE: begin
                    if (start_press) begin
                        state_q     <= S_COUNT;
                        score_q     <= '0;
                        clear_obj_q <= 1'b1;
                        frame_cnt   <= '0;
                    end else if (pause_press) begin
                        state_q  <= S_RUN;
                        run_en_q <= 1'b1;
                    end
                end
`endif
                default: begin
                    state_q   <= S_IDLE;
                    run_en_q  <= 1'b0;
                    hit_q     <= 1'b0;
                    frame_cnt <= '0;
                end
            endcase
        end
    end

    assign lvl_raw = score_q >> STEP_SH;

    assign bus.state     = state_q;
    assign bus.run_en    = run_en_q;
    assign bus.clear_obj = clear_obj_q;
    assign bus.hit       = hit_q;
    assign bus.score     = score_q;
    assign bus.score_hi  = score_hi_q;
    assign bus.level     = (lvl_raw > SCORE_W'(MAX_LEVEL)) ? 3'(MAX_LEVEL) : lvl_raw[2:0];
endmodule
